// File: rtl/adxl345_uart_formatter.sv
// adxl345_uart_formatter: serialises a packed BCD XYZ reading as an 8N1 UART text line
// Ports: Clk_i clock; Reset_i async active-low reset; Data_Available_i/Data_i capture request
// and packed BCD word; Tx_o serial line (idle high); Busy_o frame in flight; Frame_Done_o
// end-of-frame pulse; Overrun_o pulse for a request dropped while busy.
// Define ADXL345_CRLF_EN to append CR LF after the 21-byte line.
module adxl345_uart_formatter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        Clk_i,
  input  logic        Reset_i,
  input  logic        Data_Available_i,
  input  logic [32:0] Data_i,
  output logic        Tx_o,
  output logic        Busy_o,
  output logic        Frame_Done_o,
  output logic        Overrun_o
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEXT} state_t;
`ifdef ADXL345_CRLF_EN
  localparam logic [4:0] LAST_IDX = 5'd22;
`else
  localparam logic [4:0] LAST_IDX = 5'd20;
`endif
  localparam logic [15:0] BIT_END = 16'(CLKS_PER_BIT - 1);
  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [4:0]  idx_q, idx_d;
  logic [32:0] word_q, word_d;
  logic        tx_q, tx_d, busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
  logic [7:0]  byte_c;
  logic        bit_end;
  function automatic logic [7:0] asc(input logic [3:0] d);
    return (d > 4'd9) ? 8'h23 : 8'h30 + {4'h0, d};
  endfunction
  assign bit_end = baud_q == BIT_END;
  always_comb begin
    case (idx_q)
      5'd0:    byte_c = 8'h58;
      5'd1:    byte_c = 8'h3D;
      5'd2:    byte_c = asc({1'b0, word_q[26:24]});
      5'd3:    byte_c = 8'h2E;
      5'd4:    byte_c = asc(word_q[7:4]);
      5'd5:    byte_c = asc(word_q[3:0]);
      5'd7:    byte_c = 8'h59;
      5'd8:    byte_c = 8'h3D;
      5'd9:    byte_c = asc({1'b0, word_q[29:27]});
      5'd10:   byte_c = 8'h2E;
      5'd11:   byte_c = asc(word_q[15:12]);
      5'd12:   byte_c = asc(word_q[11:8]);
      5'd14:   byte_c = 8'h5A;
      5'd15:   byte_c = 8'h3D;
      5'd16:   byte_c = asc({1'b0, word_q[32:30]});
      5'd17:   byte_c = 8'h2E;
      5'd18:   byte_c = asc(word_q[23:20]);
      5'd19:   byte_c = asc(word_q[19:16]);
`ifdef ADXL345_CRLF_EN
      5'd21:   byte_c = 8'h0D;
      5'd22:   byte_c = 8'h0A;
`endif
      default: byte_c = 8'h20;
    endcase
  end
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end
  // baud counter restarts at every bit boundary and is held at zero outside the bit states
  always_comb begin
    state_d = state_q;
    baud_d  = (state_q inside {IDLE, NEXT} || bit_end) ? '0 : baud_q + 16'd1;
    bit_d   = bit_q;
    idx_d   = idx_q;
    word_d  = word_q;
    unique case (state_q)
      IDLE:  if (Data_Available_i) begin
        state_d = START;
        word_d  = Data_i;
        idx_d   = '0;
      end
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA:  if (bit_end) begin
        bit_d   = bit_q + 3'd1;
        state_d = (bit_q == 3'd7) ? STOP : DATA;
      end
      STOP:  if (bit_end) state_d = NEXT;
      NEXT:  begin
        state_d = (idx_q == LAST_IDX) ? IDLE : START;
        idx_d   = (idx_q == LAST_IDX) ? idx_q : idx_q + 5'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs are registered from the next state so the start bit lands the cycle after capture
  always_comb begin
    tx_d   = (state_d == START) ? 1'b0 : (state_d == DATA) ? byte_c[bit_d] : 1'b1;
    busy_d = state_d != IDLE;
    done_d = (state_q == NEXT) && (state_d == IDLE);
    ovr_d  = Data_Available_i && (state_q != IDLE);
  end
  assign Tx_o         = tx_q;
  assign Busy_o       = busy_q;
  assign Frame_Done_o = done_q;
  assign Overrun_o    = ovr_q;
endmodule

// File: tb/tb_adxl345_uart_formatter.sv
// tb_adxl345_uart_formatter: directed self-checking bench for the UART line formatter
module tb_adxl345_uart_formatter;
  localparam int C = 4;
`ifdef ADXL345_CRLF_EN
  localparam int N = 23;
`else
  localparam int N = 21;
`endif
  localparam int FRAME = N * (10 * C + 1);
  logic        Clk_i = 1'b0;
  logic        Reset_i = 1'b0;
  logic        Data_Available_i = 1'b0;
  logic [32:0] Data_i = '0;
  logic        Tx_o, Busy_o, Frame_Done_o, Overrun_o;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  rxq[$];
  logic [7:0]  rx_b = '0;
  logic        rx_on = 1'b0;
  int          rx_t = 0;
  int          stop_err = 0;
  int          ovr_cnt = 0;
  int          done_cnt = 0;
  adxl345_uart_formatter #(.CLKS_PER_BIT(C)) dut (
    .Clk_i(Clk_i),
    .Reset_i(Reset_i),
    .Data_Available_i(Data_Available_i),
    .Data_i(Data_i),
    .Tx_o(Tx_o),
    .Busy_o(Busy_o),
    .Frame_Done_o(Frame_Done_o),
    .Overrun_o(Overrun_o)
  );
  always #5 Clk_i = ~Clk_i;
  // UART receiver: detects a start bit and samples each bit at its centre
  always @(negedge Clk_i) begin
    if (!Reset_i) rx_on <= 1'b0;
    else if (!rx_on) begin
      rx_on <= (Tx_o === 1'b0);
      rx_t  <= 1;
    end else begin
      rx_t <= rx_t + 1;
      if (rx_t == 9 * C + C / 2) begin
        rxq.push_back(rx_b);
        rx_on <= 1'b0;
        if (Tx_o !== 1'b1) stop_err <= stop_err + 1;
      end else if (rx_t >= C + C / 2 && (rx_t - C / 2) % C == 0)
        rx_b[3'((rx_t - C / 2) / C - 1)] <= Tx_o;
    end
  end
  always @(negedge Clk_i) begin
    if (Overrun_o === 1'b1) ovr_cnt <= ovr_cnt + 1;
    if (Frame_Done_o === 1'b1) done_cnt <= done_cnt + 1;
  end
  function automatic logic [7:0] exp_byte(input string s, input int i);
    if (i < 21) return s[i];
    return (i == 21) ? 8'h0D : 8'h0A;
  endfunction
  task automatic pulse(input logic [32:0] d);
    Data_i = d;
    Data_Available_i = 1'b1;
    @(negedge Clk_i);
    Data_Available_i = 1'b0;
  endtask
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 3000 && n < 0; i++) begin
      @(negedge Clk_i);
      if (Frame_Done_o === 1'b1) n = i;
    end
  endtask
  task automatic test_reset;
    repeat (3) @(negedge Clk_i);
    checks++; if (Tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", Tx_o); end
    checks++; if (Busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy_o); end
    checks++; if (Frame_Done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", Frame_Done_o); end
    checks++; if (Overrun_o !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", Overrun_o); end
    Reset_i = 1'b1;
    @(negedge Clk_i);
  endtask
  task automatic test_frame(input logic [32:0] d, input string s, input string name);
    int n;
    logic [7:0] got;
    rxq.delete();
    pulse(d);
    Data_i = ~d;
    checks++; if (Tx_o !== 1'b0) begin errors++; $display("FAIL %s start_tx: got %b want 0", name, Tx_o); end
    checks++; if (Busy_o !== 1'b1) begin errors++; $display("FAIL %s start_busy: got %b want 1", name, Busy_o); end
    wait_done(n);
    checks++; if (n != FRAME) begin errors++; $display("FAIL %s done_time: got %0d want %0d", name, n, FRAME); end
    checks++; if (Busy_o !== 1'b0) begin errors++; $display("FAIL %s done_busy: got %b want 0", name, Busy_o); end
    checks++; if (rxq.size() != N) begin errors++; $display("FAIL %s byte_count: got %0d want %0d", name, rxq.size(), N); end
    for (int i = 0; i < N; i++) begin
      got = (i < rxq.size()) ? rxq[i] : 8'h00;
      checks++;
      if (got !== exp_byte(s, i)) begin
        errors++;
        $display("FAIL %s byte%0d: got %h want %h", name, i, got, exp_byte(s, i));
      end
    end
    @(negedge Clk_i);
    checks++; if (Frame_Done_o !== 1'b0) begin errors++; $display("FAIL %s done_width: got %b want 0", name, Frame_Done_o); end
  endtask
  task automatic test_overrun;
    int n, ovr0;
    logic [7:0] got;
    string s = "X=1.25 Y=0.50 Z=7.99 ";
    rxq.delete();
    ovr0 = ovr_cnt;
    pulse(33'h1C1995025);
    repeat (100) @(negedge Clk_i);
    pulse(33'h0B3130847);
    checks++; if (Overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_pulse: got %b want 1", Overrun_o); end
    checks++; if (Busy_o !== 1'b1) begin errors++; $display("FAIL ovr_busy: got %b want 1", Busy_o); end
    @(negedge Clk_i);
    checks++; if (Overrun_o !== 1'b0) begin errors++; $display("FAIL ovr_width: got %b want 0", Overrun_o); end
    wait_done(n);
    checks++; if (n != FRAME - 102) begin errors++; $display("FAIL ovr_done_time: got %0d want %0d", n, FRAME - 102); end
    checks++; if (ovr_cnt - ovr0 != 1) begin errors++; $display("FAIL ovr_count: got %0d want 1", ovr_cnt - ovr0); end
    for (int i = 0; i < N; i++) begin
      got = (i < rxq.size()) ? rxq[i] : 8'h00;
      checks++;
      if (got !== exp_byte(s, i)) begin
        errors++;
        $display("FAIL ovr_byte%0d: got %h want %h", i, got, exp_byte(s, i));
      end
    end
  endtask
  task automatic test_back_to_back;
    int n, ovr0;
    logic [7:0] got;
    string s = "X=3.47 Y=6.08 Z=2.13 ";
    rxq.delete();
    pulse(33'h0000000AF);
    wait_done(n);
    checks++; if (n != FRAME) begin errors++; $display("FAIL b2b_first_done: got %0d want %0d", n, FRAME); end
    rxq.delete();
    ovr0 = ovr_cnt;
    pulse(33'h0B3130847);
    checks++; if (Tx_o !== 1'b0) begin errors++; $display("FAIL b2b_start_tx: got %b want 0", Tx_o); end
    checks++; if (Busy_o !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", Busy_o); end
    checks++; if (Overrun_o !== 1'b0) begin errors++; $display("FAIL b2b_ovr: got %b want 0", Overrun_o); end
    wait_done(n);
    checks++; if (n != FRAME) begin errors++; $display("FAIL b2b_done: got %0d want %0d", n, FRAME); end
    checks++; if (ovr_cnt != ovr0) begin errors++; $display("FAIL b2b_ovr_count: got %0d want %0d", ovr_cnt, ovr0); end
    for (int i = 0; i < N; i++) begin
      got = (i < rxq.size()) ? rxq[i] : 8'h00;
      checks++;
      if (got !== exp_byte(s, i)) begin
        errors++;
        $display("FAIL b2b_byte%0d: got %h want %h", i, got, exp_byte(s, i));
      end
    end
  endtask
  task automatic test_reset_mid;
    int done0;
    pulse(33'h1C1995025);
    repeat (184) @(negedge Clk_i);
    Reset_i = 1'b0;
    #1;
    checks++; if (Tx_o !== 1'b1) begin errors++; $display("FAIL abort_tx: got %b want 1", Tx_o); end
    checks++; if (Busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", Busy_o); end
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk_i);
      checks++;
      if (Tx_o !== 1'b1 || Busy_o !== 1'b0 || Frame_Done_o !== 1'b0) begin
        errors++;
        $display("FAIL abort_hold%0d: got tx=%b busy=%b done=%b want 1 0 0", i, Tx_o, Busy_o, Frame_Done_o);
      end
    end
    Reset_i = 1'b1;
    done0 = done_cnt;
    repeat (1200) @(negedge Clk_i);
    checks++; if (done_cnt != done0) begin errors++; $display("FAIL abort_no_done: got %0d want %0d", done_cnt, done0); end
    checks++; if (Tx_o !== 1'b1 || Busy_o !== 1'b0) begin errors++; $display("FAIL abort_idle: got tx=%b busy=%b want 1 0", Tx_o, Busy_o); end
  endtask
  initial begin
    test_reset;
    test_frame(33'h1C1995025, "X=1.25 Y=0.50 Z=7.99 ", "frame_a");
    test_frame(33'h0000000AF, "X=0.## Y=0.00 Z=0.00 ", "frame_hash");
    test_frame(33'h0B3130847, "X=3.47 Y=6.08 Z=2.13 ", "frame_c");
    test_overrun;
    test_back_to_back;
    test_reset_mid;
    test_frame(33'h0B3130847, "X=3.47 Y=6.08 Z=2.13 ", "after_abort");
    checks++; if (stop_err != 0) begin errors++; $display("FAIL stop_bits: got %0d bad want 0", stop_err); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adxl345_uart_formatter.md
ADXL345_UART_FORMATTER -- requirements
Module: adxl345_uart_formatter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (115200 baud at 50 MHz); legal range 2..65535.
REQ-002 Clk_i  input  1  system clock; all logic on the rising edge.
REQ-003 Reset_i  input  1  reset, asynchronous, active-low.
REQ-004 Data_Available_i  input  1  one-cycle pulse from the data converter: Data_i is valid.
REQ-005 Data_i  input  33  packed BCD axes; [26:24]/[29:27]/[32:30] are the X/Y/Z integer digits, [7:4]/[15:12]/[23:20] the X/Y/Z tenths, [3:0]/[11:8]/[19:16] the X/Y/Z hundredths.
REQ-006 Tx_o  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-007 Busy_o  output  1  high while a frame is being transmitted.
REQ-008 Frame_Done_o  output  1  one-cycle pulse when a frame completes.
REQ-009 Overrun_o  output  1  one-cycle pulse when Data_Available_i is dropped because the block is busy.

Function
REQ-010 The FSM states SHALL be IDLE, START, DATA, STOP and NEXT.
- IDLE->START on Data_Available_i.
- START->DATA after CLKS_PER_BIT cycles.
- DATA->STOP after 8 bits.
- STOP->NEXT after CLKS_PER_BIT cycles.
- NEXT->START if bytes remain, else ->IDLE.
REQ-011 In IDLE, a clock edge with Data_Available_i high SHALL latch Data_i, clear the byte index, and enter START.
REQ-012 The start bit (Tx_o=0) SHALL begin the cycle after the capture edge; Busy_o SHALL rise in that same cycle.
REQ-013 Each bit SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter that reloads at every bit boundary.
REQ-014 NEXT SHALL last one cycle (Tx_o stays high), so consecutive bytes are separated by 1 stop bit plus 1 cycle.
REQ-015 The frame SHALL be, in order: 'X','=',Xi,'.',Xt,Xh,' ','Y','=',Yi,'.',Yt,Yh,' ','Z','=',Zi,'.',Zt,Zh,' '. This is 21 bytes before any REQ-024 suffix.
REQ-016 Digit to ASCII: a digit value of 0..9 SHALL map to 8'h30+value; a 4-bit field value of 10..15 SHALL be sent as '#' (8'h23). Integer digits are 3 bits, so 0..7 is always legal.
REQ-017 Byte selection SHALL be a combinational mux on the byte index over the latched word; Data_i changing after capture SHALL NOT affect the frame.
REQ-018 On leaving the last NEXT, the FSM SHALL enter IDLE, drop Busy_o, and pulse Frame_Done_o for exactly that first IDLE cycle.
REQ-019 Data_Available_i arriving in the cycle Frame_Done_o is high SHALL be accepted, because the FSM is in IDLE.
REQ-020 Data_Available_i arriving in any state other than IDLE SHALL be ignored, pulse Overrun_o for one cycle, and leave the frame in progress unaffected.
REQ-021 Tx_o, Busy_o, Frame_Done_o and Overrun_o SHALL be registered outputs.

Reset
REQ-022 While Reset_i is low:
- the FSM is in IDLE;
- the baud counter, bit counter, byte index and latched word are 0;
- Tx_o=1, Busy_o=0, Frame_Done_o=0, Overrun_o=0.
REQ-023 Reset asserted mid-frame SHALL abort immediately with Tx_o=1. After release, transmission resumes only on a new Data_Available_i, and no Frame_Done_o pulse is issued for the aborted frame.

Configuration
REQ-024 With macro ADXL345_CRLF_EN defined, the frame SHALL append 8'h0D and 8'h0A after byte 21, giving 23 bytes. Without it, the frame SHALL be 21 bytes and end with ' '.

Verification
REQ-025 Setup: CLKS_PER_BIT=4, ADXL345_CRLF_EN defined. Stimulus: Data_i=33'h1C1995025 pulsed once. Required: decoded line "X=1.25 Y=0.50 Z=7.99 \r\n"; Frame_Done_o pulses exactly 23*(10*4+1)=943 cycles after the start bit begins.
REQ-026 Stimulus: Data_i=33'h0000000AF. Required: X field decoded as "X=0.##".
REQ-027 Stimulus: second Data_Available_i 100 cycles into a frame. Required: one Overrun_o pulse; the first frame's bytes are unchanged; Busy_o remains high.
REQ-028 Stimulus: Data_Available_i in the Frame_Done_o cycle. Required: a new start bit on the next cycle; no Overrun_o.
REQ-029 Stimulus: Reset_i low for 3 cycles during byte 5. Required: Tx_o=1 and Busy_o=0 within the reset window; no Frame_Done_o until a new request.
REQ-030 Stimulus: rebuild without ADXL345_CRLF_EN. Required: 21-byte frame ending in 8'h20; Frame_Done_o at 21*41=861 cycles.
